// File: rtl/ts_output_arbiter.sv
// ts_output_arbiter: grants whole 188-byte TS packets to the T2-MI packer or the PSI/SI inserter; null fill under TS_NULL_FILL_EN.
// Latency: forwarded bytes are registered (n -> n+1); a request seen in S_IDLE pulses GRANT/START one cycle later.
// Backpressure: none. Sources hold their request until granted; requests seen while busy are ignored, not latched.
module ts_output_arbiter #(
  parameter int GAP_CYCLES       = 2,
  parameter int TABLE_BURST_MAX  = 2,
  parameter int WDOG_CYCLES      = 1024,
  parameter int NULL_IDLE_CYCLES = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       T2MI_REQ,
  output logic       T2MI_GRANT,
  input  logic [7:0] T2MI_DATA,
  input  logic       T2MI_ENA,
  input  logic       T2MI_PSYNC,
  input  logic       TABLE_READY,
  output logic       TABLE_START,
  input  logic [7:0] TABLE_DATA,
  input  logic       TABLE_ENA,
  input  logic       TABLE_PSYNC,
  input  logic       TABLE_SENT,
  output logic [7:0] DATA_OUT,
  output logic       ENA_OUT,
  output logic       PSYNC,
  output logic       ERR,
  output logic [2:0] state_mon
);

  localparam int              WD_W      = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(WDOG_CYCLES - 1);
  localparam logic [3:0]      GAP_LAST  = 4'(GAP_CYCLES - 1);
  localparam logic [2:0]      BURST_MAX = 3'(TABLE_BURST_MAX);
  localparam logic [7:0]      PKT_LAST  = 8'd187;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_T2MI  = 3'd1,
    S_TABLE = 3'd2,
    S_NULL  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        byte_cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic [3:0]        gap_cnt;
  logic [2:0]        burst_cnt;
  logic              table_go, wd_hit;
  logic [8:0]        tbl_total;
  logic              grant_d, start_d, err_d, ena_d, psync_d;
  logic [7:0]        dat_d;

  // Table wins a tie until the burst limit forces a T2-MI turn.
  assign table_go  = TABLE_READY && (!T2MI_REQ || burst_cnt < BURST_MAX);
  assign wd_hit    = (wd_cnt == WD_LAST);
  assign tbl_total = {1'b0, byte_cnt} + {8'd0, TABLE_ENA};
  assign state_mon = state;

`ifdef TS_NULL_FILL_EN
  localparam int                IDLE_W    = $clog2(NULL_IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(NULL_IDLE_CYCLES - 1);
  logic [IDLE_W-1:0] idle_cnt;
  logic              null_go;
  logic [7:0]        null_byte;

  assign null_go = (idle_cnt == IDLE_LAST);

  always_comb begin
    case (byte_cnt)
      8'd0:    null_byte = 8'h47;
      8'd1:    null_byte = 8'h1F;
      8'd3:    null_byte = 8'h10;
      default: null_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                 idle_cnt <= '0;
    else if (state == S_IDLE) idle_cnt <= idle_cnt + IDLE_W'(1);
    else                     idle_cnt <= '0;
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (table_go)      state_nxt = S_TABLE;
        else if (T2MI_REQ) state_nxt = S_T2MI;
`ifdef TS_NULL_FILL_EN
        else if (null_go)  state_nxt = S_NULL;
`endif
      end
      S_T2MI: begin
        if (T2MI_ENA ? (byte_cnt == PKT_LAST) : wd_hit) state_nxt = S_GAP;
      end
      S_TABLE: begin
        if (TABLE_SENT || (!TABLE_ENA && wd_hit)) state_nxt = S_GAP;
      end
`ifdef TS_NULL_FILL_EN
      S_NULL: begin
        if (byte_cnt == PKT_LAST) state_nxt = S_GAP;
      end
`endif
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d = 1'b0;
    start_d = 1'b0;
    err_d   = 1'b0;
    dat_d   = 8'd0;
    ena_d   = 1'b0;
    psync_d = 1'b0;
    case (state)
      S_IDLE: begin
        start_d = table_go;
        grant_d = !table_go && T2MI_REQ;
      end
      S_T2MI: begin
        dat_d   = T2MI_DATA;
        ena_d   = T2MI_ENA;
        psync_d = T2MI_PSYNC;
        err_d   = !T2MI_ENA && wd_hit;
      end
      S_TABLE: begin
        dat_d   = TABLE_DATA;
        ena_d   = TABLE_ENA;
        psync_d = TABLE_PSYNC;
        // The byte arriving with TABLE_SENT still belongs to the packet.
        err_d   = TABLE_SENT ? (tbl_total != 9'd188) : (!TABLE_ENA && wd_hit);
      end
`ifdef TS_NULL_FILL_EN
      S_NULL: begin
        dat_d   = null_byte;
        ena_d   = 1'b1;
        psync_d = (byte_cnt == 8'd0);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      T2MI_GRANT  <= 1'b0;
      TABLE_START <= 1'b0;
      ERR         <= 1'b0;
      DATA_OUT    <= 8'd0;
      ENA_OUT     <= 1'b0;
      PSYNC       <= 1'b0;
    end else begin
      T2MI_GRANT  <= grant_d;
      TABLE_START <= start_d;
      ERR         <= err_d;
      DATA_OUT    <= dat_d;
      ENA_OUT     <= ena_d;
      PSYNC       <= psync_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      byte_cnt  <= 8'd0;
      wd_cnt    <= '0;
      gap_cnt   <= 4'd0;
      burst_cnt <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          byte_cnt <= 8'd0;
          wd_cnt   <= '0;
          gap_cnt  <= 4'd0;
          if (table_go)      burst_cnt <= (burst_cnt == 3'd7) ? 3'd7 : burst_cnt + 3'd1;
          else if (T2MI_REQ) burst_cnt <= 3'd0;
        end
        S_T2MI: begin
          if (T2MI_ENA) begin
            byte_cnt <= byte_cnt + 8'd1;
            wd_cnt   <= '0;
          end else begin
            wd_cnt   <= wd_cnt + WD_W'(1);
          end
        end
        S_TABLE: begin
          // Saturate so an overlong table cannot wrap back to a legal count.
          if (TABLE_ENA) begin
            if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
`ifdef TS_NULL_FILL_EN
        S_NULL: byte_cnt <= byte_cnt + 8'd1;
`endif
        S_GAP: begin
          byte_cnt <= 8'd0;
          wd_cnt   <= '0;
          gap_cnt  <= (gap_cnt == GAP_LAST) ? 4'd0 : gap_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ts_output_arbiter.sv
// Scoreboard bench for ts_output_arbiter: stimulus queues expected bytes, grants, errors and state samples; a negedge monitor checks them.
module tb_ts_output_arbiter;

`ifdef TS_NULL_FILL_EN
  localparam int NULL_IDLE = 16;
`else
  localparam int NULL_IDLE = 4096;
`endif

  logic       CLK, RST;
  logic       T2MI_REQ, T2MI_GRANT, T2MI_ENA, T2MI_PSYNC;
  logic [7:0] T2MI_DATA;
  logic       TABLE_READY, TABLE_START, TABLE_ENA, TABLE_PSYNC, TABLE_SENT;
  logic [7:0] TABLE_DATA;
  logic [7:0] DATA_OUT;
  logic       ENA_OUT, PSYNC, ERR;
  logic [2:0] state_mon;

  ts_output_arbiter #(
    .GAP_CYCLES(2), .TABLE_BURST_MAX(2), .WDOG_CYCLES(1024), .NULL_IDLE_CYCLES(NULL_IDLE)
  ) dut (
    .CLK(CLK), .RST(RST),
    .T2MI_REQ(T2MI_REQ), .T2MI_GRANT(T2MI_GRANT), .T2MI_DATA(T2MI_DATA),
    .T2MI_ENA(T2MI_ENA), .T2MI_PSYNC(T2MI_PSYNC),
    .TABLE_READY(TABLE_READY), .TABLE_START(TABLE_START), .TABLE_DATA(TABLE_DATA),
    .TABLE_ENA(TABLE_ENA), .TABLE_PSYNC(TABLE_PSYNC), .TABLE_SENT(TABLE_SENT),
    .DATA_OUT(DATA_OUT), .ENA_OUT(ENA_OUT), .PSYNC(PSYNC), .ERR(ERR),
    .state_mon(state_mon)
  );

  typedef struct { int cyc; logic [7:0] dat; logic ps; } byte_e_t;
  typedef struct { int cyc; int val; } ev_t;

  byte_e_t bq[$];
  ev_t     gq[$], eq[$], sq[$];
  int      cyc = 0;
  int      checks = 0, failures = 0;
  int      tmo_cnt = 0, tmo_seen = 0;
  bit      done = 0;
  byte_e_t be;
  ev_t     ev;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    while (tmo_seen < tmo_cnt) begin
      checks++; failures++; tmo_seen++;
      $display("FAIL wait_timeout got=no_grant exp=grant cyc=%0d", cyc);
    end
    if (RST) begin
      checks++;
      if ({DATA_OUT, ENA_OUT, PSYNC, T2MI_GRANT, TABLE_START, ERR, state_mon} !== 16'd0) begin
        failures++;
        $display("FAIL reset_outputs got=%h exp=0 cyc=%0d",
                 {DATA_OUT, ENA_OUT, PSYNC, T2MI_GRANT, TABLE_START, ERR, state_mon}, cyc);
      end
    end else begin
      if (ENA_OUT) begin
        checks++;
        if (bq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_byte got=%h exp=none cyc=%0d", DATA_OUT, cyc);
        end else begin
          be = bq.pop_front();
          if (DATA_OUT !== be.dat || PSYNC !== be.ps || cyc != be.cyc) begin
            failures++;
            $display("FAIL out_byte got=%h/ps%0b@%0d exp=%h/ps%0b@%0d",
                     DATA_OUT, PSYNC, cyc, be.dat, be.ps, be.cyc);
          end
        end
      end
      if (T2MI_GRANT || TABLE_START) begin
        checks++;
        if (gq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_grant got=t2mi%0b/table%0b exp=none cyc=%0d", T2MI_GRANT, TABLE_START, cyc);
        end else begin
          ev = gq.pop_front();
          if ((T2MI_GRANT && TABLE_START) || ev.val != (TABLE_START ? 1 : 0) || ev.cyc != cyc) begin
            failures++;
            $display("FAIL grant got=t2mi%0b/table%0b@%0d exp=kind%0d@%0d",
                     T2MI_GRANT, TABLE_START, cyc, ev.val, ev.cyc);
          end
        end
      end
      if (ERR) begin
        checks++;
        if (eq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_err got=1 exp=0 cyc=%0d", cyc);
        end else begin
          ev = eq.pop_front();
          if (ev.cyc != cyc) begin
            failures++;
            $display("FAIL err_time got=%0d exp=%0d", cyc, ev.cyc);
          end
        end
      end
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        ev = sq.pop_front();
        checks++; failures++;
        $display("FAIL state_missed got=none exp=%0d@%0d", ev.val, ev.cyc);
      end
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        ev = sq.pop_front();
        checks++;
        if (int'(state_mon) != ev.val) begin
          failures++;
          $display("FAIL state got=%0d exp=%0d cyc=%0d", state_mon, ev.val, cyc);
        end
      end
    end
    if (done) begin
      checks++;
      if (bq.size() != 0) begin failures++; $display("FAIL bytes_left got=%0d exp=0", bq.size()); end
      checks++;
      if (gq.size() != 0) begin failures++; $display("FAIL grants_left got=%0d exp=0", gq.size()); end
      checks++;
      if (eq.size() != 0) begin failures++; $display("FAIL errs_left got=%0d exp=0", eq.size()); end
      checks++;
      if (sq.size() != 0) begin failures++; $display("FAIL states_left got=%0d exp=0", sq.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic wait_any(output int kind, output int gcyc);
    kind = -1; gcyc = -1;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (T2MI_GRANT || TABLE_START) begin
        kind = TABLE_START ? 1 : 0;
        gcyc = cyc;
        return;
      end
    end
    tmo_cnt++;
  endtask

  // First byte is driven in the grant cycle; each output is expected one cycle later.
  task automatic send_t2mi(input int n, input int seed);
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      T2MI_ENA   = 1'b1;
      T2MI_PSYNC = (i == 0);
      T2MI_DATA  = (i == 0) ? 8'h47 : 8'(i + seed);
      bq.push_back('{cyc + 1, T2MI_DATA, T2MI_PSYNC});
    end
    tick();
    T2MI_ENA = 1'b0; T2MI_PSYNC = 1'b0; T2MI_DATA = 8'd0;
  endtask

  task automatic send_table(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      TABLE_ENA   = 1'b1;
      TABLE_PSYNC = (i == 0);
      TABLE_DATA  = (i == 0) ? 8'h47 : 8'(i + 128);
      TABLE_SENT  = (i == n - 1);
      bq.push_back('{cyc + 1, TABLE_DATA, TABLE_PSYNC});
    end
    tick();
    TABLE_ENA = 1'b0; TABLE_PSYNC = 1'b0; TABLE_DATA = 8'd0; TABLE_SENT = 1'b0;
  endtask

  initial begin
    int r, c, g, kd;
    int kinds[6];
    RST = 1'b1;
    T2MI_REQ = 0; T2MI_ENA = 0; T2MI_PSYNC = 0; T2MI_DATA = 0;
    TABLE_READY = 0; TABLE_ENA = 0; TABLE_PSYNC = 0; TABLE_DATA = 0; TABLE_SENT = 0;
    kinds[0] = 1; kinds[1] = 1; kinds[2] = 0; kinds[3] = 1; kinds[4] = 1; kinds[5] = 0;
    repeat (3) tick();
    RST = 1'b0;
    r = cyc;

`ifdef TS_NULL_FILL_EN
    // Null packet: S_NULL after 16 idle cycles, first byte one cycle later.
    sq.push_back('{r + 16, 3});
    for (int i = 0; i < 188; i++)
      bq.push_back('{r + 17 + i, (i == 0) ? 8'h47 : (i == 1) ? 8'h1F : (i == 3) ? 8'h10 : 8'hFF, (i == 0)});
    sq.push_back('{r + 204, 4});
    sq.push_back('{r + 206, 0});
    repeat (210) tick();
`else
    // No null fill: remains idle, ENA_OUT quiet.
    sq.push_back('{r + 17, 0});
    sq.push_back('{r + 40, 0});
    repeat (45) tick();

    // T2-MI only.
    T2MI_REQ = 1'b1; c = cyc;
    gq.push_back('{c + 1, 0});
    wait_any(kd, g);
    T2MI_REQ = 1'b0;
    sq.push_back('{g + 188, 4});
    sq.push_back('{g + 189, 4});
    sq.push_back('{g + 190, 0});
    send_t2mi(188, 1);
    repeat (5) tick();

    // Both requesters held: TABLE, TABLE, T2MI repeating, 191 cycles apart.
    T2MI_REQ = 1'b1; TABLE_READY = 1'b1; c = cyc;
    for (int k = 0; k < 6; k++) gq.push_back('{c + 1 + k * 191, kinds[k]});
    for (int k = 0; k < 6; k++) begin
      wait_any(kd, g);
      if (k == 5) begin T2MI_REQ = 1'b0; TABLE_READY = 1'b0; end
      if (kd == 1) send_table(188);
      else         send_t2mi(188, k * 16);
    end
    repeat (5) tick();

    // Short table: 187 bytes then TABLE_SENT.
    TABLE_READY = 1'b1; c = cyc;
    gq.push_back('{c + 1, 1});
    wait_any(kd, g);
    TABLE_READY = 1'b0;
    eq.push_back('{g + 187, 1});
    sq.push_back('{g + 187, 4});
    sq.push_back('{g + 188, 4});
    sq.push_back('{g + 189, 0});
    send_table(187);
    repeat (5) tick();

    // Watchdog: packer stalls after 100 bytes.
    T2MI_REQ = 1'b1; c = cyc;
    gq.push_back('{c + 1, 0});
    wait_any(kd, g);
    T2MI_REQ = 1'b0;
    eq.push_back('{g + 1124, 1});
    sq.push_back('{g + 1123, 1});
    sq.push_back('{g + 1124, 4});
    sq.push_back('{g + 1126, 0});
    send_t2mi(100, 7);
    repeat (1035) tick();

    // Reset while byte 50 is on the output, then a normal packet.
    T2MI_REQ = 1'b1; c = cyc;
    gq.push_back('{c + 1, 0});
    wait_any(kd, g);
    T2MI_REQ = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i > 0) tick();
      T2MI_ENA = 1'b1; T2MI_PSYNC = (i == 0);
      T2MI_DATA = (i == 0) ? 8'h47 : 8'(i + 3);
      bq.push_back('{cyc + 1, T2MI_DATA, T2MI_PSYNC});
    end
    tick();
    T2MI_PSYNC = 1'b0; T2MI_DATA = 8'(53);
    tick();
    RST = 1'b1;
    T2MI_ENA = 1'b0; T2MI_DATA = 8'd0;
    repeat (2) tick();
    RST = 1'b0;
    tick();
    T2MI_REQ = 1'b1; c = cyc;
    gq.push_back('{c + 1, 0});
    wait_any(kd, g);
    T2MI_REQ = 1'b0;
    send_t2mi(188, 99);
    repeat (5) tick();
`endif
    done = 1'b1;
  end

endmodule

// File: doc/ts_output_arbiter.md
# ts_output_arbiter

Arbitrates the single 8-bit TS output of the T2-MI packer between two packet sources: the T2-MI packet stream and the PSI/SI table inserter (PAT/PMT/SDT). Grants whole 188-byte packets only, never interleaving bytes, and guards each grant with a byte counter and a stall watchdog. Optionally fills idle time with null packets (PID 0x1FFF). Sits between the packer/table inserter and the TS output formatter.

## Interface
- `GAP_CYCLES`, 2: minimum idle cycles (ENA_OUT=0) after every packet, 1..15.
- `TABLE_BURST_MAX`, 2: max consecutive table packets while T2MI_REQ is pending, 1..7.
- `WDOG_CYCLES`, 1024: cycles without an input byte before a granted packet is aborted.
- `NULL_IDLE_CYCLES`, 4096: idle cycles in S_IDLE before a null packet is emitted (NULL_FILL_EN only).
- `CLK` in 1: system clock.
- `RST` in 1: asynchronous reset, active-high.
- `T2MI_REQ` in 1: packer holds one complete packet.
- `T2MI_GRANT` out 1: one-cycle pulse; packer starts streaming.
- `T2MI_DATA` in 8, `T2MI_ENA` in 1, `T2MI_PSYNC` in 1: packer byte stream.
- `TABLE_READY` in 1: table inserter has a table pending.
- `TABLE_START` out 1: one-cycle pulse to the inserter's START.
- `TABLE_DATA` in 8, `TABLE_ENA` in 1, `TABLE_PSYNC` in 1, `TABLE_SENT` in 1: inserter stream and completion pulse.
- `DATA_OUT` out 8, `ENA_OUT` out 1, `PSYNC` out 1: arbitrated TS stream.
- `ERR` out 1: one-cycle pulse on watchdog abort or wrong packet length.
- `state_mon` out 3: current state code.

## Operation
- States: S_IDLE=0, S_T2MI=1, S_TABLE=2, S_NULL=3, S_GAP=4.
- S_IDLE decision, evaluated every cycle, first match wins:
  - TABLE_READY && (!T2MI_REQ || burst_cnt < TABLE_BURST_MAX): pulse TABLE_START, burst_cnt++ (saturating at 7), go to S_TABLE.
  - T2MI_REQ: pulse T2MI_GRANT, burst_cnt=0, go to S_T2MI.
  - NULL_FILL_EN && idle_cnt == NULL_IDLE_CYCLES-1: go to S_NULL.
- idle_cnt counts cycles spent in S_IDLE and clears on leaving S_IDLE.
- S_T2MI: forward T2MI_* only. byte_cnt (8 bit) counts T2MI_ENA cycles. After the 188th byte, go to S_GAP.
- S_TABLE: forward TABLE_* only. Exit to S_GAP on TABLE_SENT. If byte_cnt != 188 at TABLE_SENT, pulse ERR.
- Watchdog, S_T2MI/S_TABLE: wd_cnt clears on every enabled input byte. At WDOG_CYCLES-1, pulse ERR and go to S_GAP; the partial packet is not padded.
- S_NULL: emit 188 consecutive bytes with ENA_OUT=1: 0x47, 0x1F, 0xFF, 0x10, then 184×0xFF. PSYNC is high on the first byte only. Then go to S_GAP.
- S_GAP: hold GAP_CYCLES cycles, clear byte_cnt and wd_cnt, go to S_IDLE.
- Inputs from the non-selected source are ignored, including TABLE_SENT outside S_TABLE.
- TABLE_READY and T2MI_REQ sampled while busy are only acted on in S_IDLE; nothing is latched.

## Timing
- Reset values: DATA_OUT=0, ENA_OUT=0, PSYNC=0, T2MI_GRANT=0, TABLE_START=0, ERR=0, state_mon=0. All counters are 0 and state is S_IDLE.
- Reset asserted mid-packet aborts immediately. No ERR is generated.
- Forwarding latency: input byte at cycle n appears registered on DATA_OUT/ENA_OUT/PSYNC at cycle n+1.
- When not forwarding and not in S_NULL: ENA_OUT=0, PSYNC=0, DATA_OUT=0.
- Decision latency: request seen in S_IDLE at cycle n gives GRANT/START high at cycle n+1 and the state change at n+1.
- A null packet's first byte appears at ENA_OUT one cycle after entering S_NULL.
- Minimum spacing between the last byte of one packet and the first of the next: GAP_CYCLES+2 cycles.
- Simultaneous TABLE_READY and T2MI_REQ: table wins unless burst_cnt has reached TABLE_BURST_MAX.

## Configuration
- `TS_NULL_FILL_EN` defined: S_NULL and idle_cnt are built, and null packets are emitted after NULL_IDLE_CYCLES idle cycles.
- `TS_NULL_FILL_EN` undefined: S_NULL is unreachable and not synthesized. ENA_OUT stays 0 while idle; the output rate is source-driven.

## Test plan
- T2MI_REQ only, packer streams 188 bytes → one GRANT pulse; 188 bytes out delayed 1 cycle with PSYNC on byte 0; ENA_OUT=0 for 2 cycles after; ERR never pulses.
- TABLE_READY and T2MI_REQ held together, TABLE_BURST_MAX=2 → grant order TABLE, TABLE, T2MI, TABLE, TABLE, T2MI…
- Table source sends 187 bytes then TABLE_SENT → ERR pulses once; arbiter returns to S_IDLE after GAP_CYCLES.
- Packer granted but stops after 100 bytes, WDOG_CYCLES=1024 → ERR exactly 1024 cycles after byte 100; state passes through S_GAP (4) to S_IDLE (0).
- TS_NULL_FILL_EN defined, no requests, NULL_IDLE_CYCLES=16 → null packet 47 1F FF 10 FF… (188 bytes) starting 17 cycles after entering idle. With the macro undefined → ENA_OUT stays 0.
- RST pulsed high during byte 50 of a T2-MI packet → all outputs 0 asynchronously; after release, a new T2MI_REQ is granted normally.
